// File: rtl/ehl_cdc_pkg.sv
// Shared definitions for the toggle-handshake CDC blocks: FSM encoding and handshake
// reset levels.
package ehl_cdc_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StWait = 2'd2
  } hs_state_e;

  // Reset level of the req toggle and of the synchronized ack; they must agree so that
  // an idle handshake comes out of reset balanced.
  localparam logic ReqInitVal = 1'b0;
  localparam logic AckInitVal = 1'b0;

endpackage

// File: rtl/ehl_cdc.sv
// Multi-flop level synchronizer for signals that cross into the clk domain.
// TECHNOLOGY selects the implementation; 0 is the generic flop chain.
module ehl_cdc #(
  parameter int unsigned      TECHNOLOGY = 0,
  parameter int unsigned      WIDTH      = 1,
  parameter int unsigned      SYNC_STAGE = 2,
  parameter logic [WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [SYNC_STAGE-1:0][WIDTH-1:0] sync_q;

  if (TECHNOLOGY == 0) begin : g_generic
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync_q <= {SYNC_STAGE{INIT_VAL}};
      end else begin
        sync_q <= {sync_q[SYNC_STAGE-2:0], data_in};
      end
    end
  end else begin : g_tech
    // No vendor synchronizer cell is mapped yet, so every technology uses the flop chain.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync_q <= {SYNC_STAGE{INIT_VAL}};
      end else begin
        sync_q <= {sync_q[SYNC_STAGE-2:0], data_in};
      end
    end
  end

  assign data_out = sync_q[SYNC_STAGE-1];

endmodule

// File: rtl/ehl_cdc_hs_tx.sv
// Source side of a toggle req/ack handshake: registers a payload, toggles req_out one
// cycle later and waits until the synchronized ack toggle matches before accepting more.
module ehl_cdc_hs_tx
  import ehl_cdc_pkg::*;
#(
  parameter int unsigned      TECHNOLOGY = 0,
  parameter int unsigned      WIDTH      = 8,
  parameter int unsigned      SYNC_STAGE = 2,
  parameter logic [WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic [WIDTH-1:0] data_out,
  output logic             req_out,
  input  logic             ack_in,
  output logic             done,
  output logic             err
);

  hs_state_e        state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             req_q, req_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ack_s;

  ehl_cdc #(
    .TECHNOLOGY(TECHNOLOGY),
    .WIDTH     (1),
    .SYNC_STAGE(SYNC_STAGE),
    .INIT_VAL  (AckInitVal)
  ) u_ack_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .data_in (ack_in),
    .data_out(ack_s)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    req_d   = req_q;
    done_d  = 1'b0;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (valid_in) begin
          data_d  = data_in;
          state_d = StLoad;
        end
      end
      StLoad: begin
        // Payload was registered last cycle, so it is stable before req toggles.
        req_d   = ~req_q;
        state_d = StWait;
      end
      StWait: begin
        if (ack_s == req_q) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outside WAIT the ack must already match req; any difference is a protocol fault.
    if ((state_q == StIdle || state_q == StLoad) && (ack_s != req_q)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      data_q  <= INIT_VAL;
      req_q   <= ReqInitVal;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      req_q   <= req_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ready    = (state_q == StIdle);
  assign data_out = data_q;
  assign req_out  = req_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ehl_cdc_hs_tx.sv
// Directed bench for ehl_cdc_hs_tx; req_out is looped back to ack_in through a
// reset-cleared delay line of ack_dly cycles, with an optional inversion for fault cases.
module tb_ehl_cdc_hs_tx;

  localparam int unsigned Width   = 8;
  localparam logic [7:0]  InitVal = 8'h5A;

  logic             clk;
  logic             reset_n;
  logic             valid_in;
  logic [Width-1:0] data_in;
  logic             ready;
  logic [Width-1:0] data_out;
  logic             req_out;
  logic             ack_in;
  logic             done;
  logic             err;

  int unsigned ack_dly;
  logic        ack_flip;
  logic [15:0] dly_q;

  int n_cmp;
  int n_mis;

  ehl_cdc_hs_tx #(
    .TECHNOLOGY(0),
    .WIDTH     (Width),
    .SYNC_STAGE(2),
    .INIT_VAL  (InitVal)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .valid_in(valid_in),
    .data_in (data_in),
    .ready   (ready),
    .data_out(data_out),
    .req_out (req_out),
    .ack_in  (ack_in),
    .done    (done),
    .err     (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) dly_q <= '0;
    else          dly_q <= {dly_q[14:0], req_out};
  end

  always_comb begin
    ack_in = req_out;
    if (ack_dly != 0) ack_in = dly_q[ack_dly-1];
    ack_in = ack_in ^ ack_flip;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    ack_dly  = 0;
    ack_flip = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    #1;
    n_cmp++;
    if (ready !== 1'b1) begin n_mis++; $display("FAIL reset_ready got %b want 1", ready); end
    n_cmp++;
    if (req_out !== 1'b0) begin n_mis++; $display("FAIL reset_req got %b want 0", req_out); end
    n_cmp++;
    if (data_out !== InitVal) begin
      n_mis++; $display("FAIL reset_data got %h want %h", data_out, InitVal);
    end
    n_cmp++;
    if (done !== 1'b0 || err !== 1'b0) begin
      n_mis++; $display("FAIL reset_done_err got %b%b want 00", done, err);
    end
  endtask

  task automatic test_single();
    ack_dly  = 0;
    valid_in = 1'b1;
    data_in  = 8'hA5;
    tick();  // accept edge
    valid_in = 1'b0;
    n_cmp++;
    if (data_out !== 8'hA5 || req_out !== 1'b0 || ready !== 1'b0) begin
      n_mis++; $display("FAIL single_load got d=%h r=%b rdy=%b want d=a5 r=0 rdy=0",
                        data_out, req_out, ready);
    end
    tick();  // req toggle edge
    n_cmp++;
    if (req_out !== 1'b1) begin n_mis++; $display("FAIL single_toggle got %b want 1", req_out); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_cmp++;
      if (done !== (i == 3)) begin
        n_mis++; $display("FAIL single_done cycle %0d got %b want %b", i, done, (i == 3));
      end
      if (i == 3) begin
        n_cmp++;
        if (ready !== 1'b1) begin n_mis++; $display("FAIL single_ready got %b want 1", ready); end
      end
    end
    n_cmp++;
    if (err !== 1'b0) begin n_mis++; $display("FAIL single_err got %b want 0", err); end
  endtask

  task automatic test_busy_ignore();
    int   dones;
    int   toggles;
    logic req_prev;
    logic data_ok;
    dones    = 0;
    toggles  = 0;
    data_ok  = 1'b1;
    req_prev = req_out;
    ack_dly  = 0;
    valid_in = 1'b1;
    data_in  = 8'hA5;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) data_in = 8'h3C;
      if (i == 3) valid_in = 1'b0;
      if (done === 1'b1) dones++;
      if (req_out !== req_prev) toggles++;
      req_prev = req_out;
      if (data_out !== 8'hA5) data_ok = 1'b0;
    end
    n_cmp++;
    if (data_ok !== 1'b1) begin n_mis++; $display("FAIL busy_data got %h want a5", data_out); end
    n_cmp++;
    if (dones != 1) begin n_mis++; $display("FAIL busy_done_count got %0d want 1", dones); end
    n_cmp++;
    if (toggles != 1) begin n_mis++; $display("FAIL busy_toggles got %0d want 1", toggles); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [4];
    logic [7:0] cur;
    int   idx;
    int   dones;
    int   toggles;
    int   bad;
    int   cyc;
    logic acc;
    logic req_prev;
    words    = '{8'h01, 8'h02, 8'h03, 8'h04};
    idx      = 0;
    dones    = 0;
    toggles  = 0;
    bad      = 0;
    cyc      = 0;
    cur      = data_out;
    req_prev = req_out;
    ack_dly  = 5;
    valid_in = 1'b1;
    data_in  = words[0];
    while (dones < 4 && cyc < 200) begin
      acc = ready & valid_in;
      tick();
      cyc++;
      if (acc) begin
        cur = words[idx];
        idx++;
        if (idx == 4) valid_in = 1'b0;
        else          data_in  = words[idx];
      end
      if (data_out !== cur) bad++;
      if (done === 1'b1) dones++;
      if (req_out !== req_prev) toggles++;
      req_prev = req_out;
    end
    n_cmp++;
    if (dones != 4) begin n_mis++; $display("FAIL b2b_done_count got %0d want 4", dones); end
    n_cmp++;
    if (toggles != 4) begin n_mis++; $display("FAIL b2b_toggles got %0d want 4", toggles); end
    n_cmp++;
    if (bad != 0 || data_out !== 8'h04) begin
      n_mis++; $display("FAIL b2b_data_stable got %0d unstable, last %h want 0, 04", bad, data_out);
    end
    n_cmp++;
    if (err !== 1'b0) begin n_mis++; $display("FAIL b2b_err got %b want 0", err); end
    repeat (8) tick();
  endtask

  task automatic test_spurious_ack();
    ack_dly  = 0;
    ack_flip = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (err !== 1'b0) begin n_mis++; $display("FAIL spur_early got %b want 0", err); end
    tick();
    n_cmp++;
    if (err !== 1'b1) begin n_mis++; $display("FAIL spur_set got %b want 1", err); end
    ack_flip = 1'b0;
    repeat (5) tick();
    n_cmp++;
    if (err !== 1'b1) begin n_mis++; $display("FAIL spur_sticky got %b want 1", err); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if (err !== 1'b0) begin n_mis++; $display("FAIL spur_clear got %b want 0", err); end
  endtask

  task automatic test_reset_mid_wait();
    int dones;
    dones    = 0;
    ack_dly  = 0;
    valid_in = 1'b1;
    data_in  = 8'hC3;
    tick();
    valid_in = 1'b0;
    tick();
    n_cmp++;
    if (req_out !== 1'b1) begin n_mis++; $display("FAIL rmw_toggle got %b want 1", req_out); end
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (req_out !== 1'b0 || data_out !== InitVal || done !== 1'b0) begin
      n_mis++; $display("FAIL rmw_abort got r=%b d=%h done=%b want r=0 d=%h done=0",
                        req_out, data_out, done, InitVal);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    n_cmp++;
    if (dones != 0) begin n_mis++; $display("FAIL rmw_no_done got %0d want 0", dones); end
    valid_in = 1'b1;
    data_in  = 8'h77;
    tick();
    valid_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    n_cmp++;
    if (dones != 1 || data_out !== 8'h77 || req_out !== 1'b1 || err !== 1'b0) begin
      n_mis++; $display("FAIL rmw_resume got done=%0d d=%h r=%b e=%b want 1 77 1 0",
                        dones, data_out, req_out, err);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    test_reset();
    test_single();
    test_busy_ignore();
    test_back_to_back();
    test_spurious_ack();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
